// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types, defaults and helpers for the key scan front end
package key_scan_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, WAIT_REL} scan_state_t;

  localparam int N_KEYS_DEF    = 8;
  localparam int DB_CYCLES_DEF = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS    = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  function automatic logic is_single(logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-count debounce for one key
module key_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic deb
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Any single cycle of agreement clears the count, so short glitches never toggle deb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_onehot_scan.sv
// rtl/key_onehot_scan.sv - debounced key scan that only ever presents a single accepted press
module key_onehot_scan
  import key_scan_pkg::*;
#(
  parameter int N_KEYS    = N_KEYS_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] onehot,
  output logic              onehot_en,
  output logic              press_pulse,
  output logic              multi_err
);

  logic [N_KEYS-1:0] deb;
  logic [1:0]        state;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_raw[i]),
      .deb     (deb[i])
    );
  end

  // A multi-key condition is only cleared by a full release; a lone leftover key is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      onehot      <= '0;
      onehot_en   <= 1'b0;
      press_pulse <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (deb != '0) begin
            if (is_single(deb)) begin
              state       <= ST_PRESS;
              onehot      <= deb;
              onehot_en   <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              state     <= ST_WAIT_REL;
              multi_err <= 1'b1;
            end
          end
        end
        ST_PRESS: begin
          if (deb == '0) begin
            state     <= ST_IDLE;
            onehot    <= '0;
            onehot_en <= 1'b0;
          end else if (deb != onehot) begin
            state     <= ST_WAIT_REL;
            onehot    <= '0;
            onehot_en <= 1'b0;
            multi_err <= 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (deb == '0) begin
            state     <= ST_IDLE;
            multi_err <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          onehot    <= '0;
          onehot_en <= 1'b0;
          multi_err <= 1'b0;
        end
      endcase
    end
  end

endmodule
